// File: rtl/skywave_pkg.sv
// skywave_pkg: shared types and helpers for the Skywave-A reset sequencer.
//   rstseq_state_e : sequencer FSM states
//   max4()         : largest of four ints, used to size the shared counter
package skywave_pkg;

  typedef enum logic [2:0] {
    PLLRST    = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RELEASE   = 3'd3,
    RUN       = 3'd4,
    SWHOLD    = 3'd5
  } rstseq_state_e;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/skywave_sync2.sv
// skywave_sync2: generic two-flop synchronizer, async active-high reset to 0.
//   clk  : destination clock
//   rst  : asynchronous active-high reset
//   din  : asynchronous input bits
//   dout : synchronized output bits (two cycles of latency)
module skywave_sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] meta_p0;
  logic [WIDTH-1:0] sync_p1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      // stage p0: capture, may go metastable
      meta_p0 <= din;
      // stage p1: resolved copy
      sync_p1 <= meta_p0;
    end
  end

  assign dout = sync_p1;

endmodule

// File: rtl/skywave_rst_seq.sv
// skywave_rst_seq: clock/reset sequencer for the Skywave-A SoC.
// Holds the PLL in reset after power-on, qualifies PLL lock over a stable
// window, then releases NSTAGES reset domains in ascending order. Lock loss
// or a software request re-asserts every domain reset at once.
//   clk_i        : system clock
//   reset_i      : asynchronous active-high reset
//   pll_locked_i : PLL lock, asynchronous to clk_i
//   sw_rst_req_i : single-cycle software reset request
//   pll_rst_o    : PLL reset, active-high
//   stage_rst_o  : per-domain resets, active-high, bit 0 released first
//   ready_o      : high only when every domain is released
//   wdt_trip_o   : one-cycle pulse on lock-watchdog timeout
// Optional feature macro: SKYWAVE_RSTSEQ_WDT_EN enables the lock watchdog;
// without it wdt_trip_o is tied low and WAIT_LOCK waits indefinitely.
module skywave_rst_seq
  import skywave_pkg::*;
#(
  parameter int NSTAGES        = 4,
  parameter int PLL_RST_CYCLES = 4,
  parameter int LOCK_CYCLES    = 256,
  parameter int STAGE_GAP      = 16,
  parameter int SWRST_HOLD     = 8,
  parameter int WDT_CYCLES     = 65536
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               pll_locked_i,
  input  logic               sw_rst_req_i,
  output logic               pll_rst_o,
  output logic [NSTAGES-1:0] stage_rst_o,
  output logic               ready_o,
  output logic               wdt_trip_o
);

  // One counter serves every timed state; it is cleared on each state entry.
  localparam int CNT_MAX = max4(PLL_RST_CYCLES, LOCK_CYCLES, STAGE_GAP, SWRST_HOLD);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  rstseq_state_e      state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [NSTAGES-1:0] stage_rst, stage_n;
  logic               pll_rst, pll_n;
  logic               ready, ready_n;
  logic               trip, trip_n;
  logic               lock_s;
  logic               wdt_hit;

  skywave_sync2 #(.WIDTH(1)) u_lock_sync (
    .clk  (clk_i),
    .rst  (reset_i),
    .din  (pll_locked_i),
    .dout (lock_s)
  );

`ifdef SKYWAVE_RSTSEQ_WDT_EN
  localparam int WDT_W = $clog2(WDT_CYCLES + 1);
  logic [WDT_W-1:0] wdt_cnt, wdt_cnt_n;
  logic             in_lock_wait, next_lock_wait;

  assign in_lock_wait   = (state == WAIT_LOCK) || (state == STABLE);
  assign next_lock_wait = (state_n == WAIT_LOCK) || (state_n == STABLE);
  assign wdt_hit        = in_lock_wait && (wdt_cnt == WDT_W'(WDT_CYCLES - 1));
  // Keeps counting across WAIT_LOCK <-> STABLE bounces; any other entry clears it.
  assign wdt_cnt_n      = (in_lock_wait && next_lock_wait) ? wdt_cnt + 1'b1 : '0;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) wdt_cnt <= '0;
    else         wdt_cnt <= wdt_cnt_n;
  end
`else
  logic unused_wdt;
  assign wdt_hit    = 1'b0;
  assign unused_wdt = ^WDT_CYCLES;
`endif

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    stage_n = stage_rst;
    pll_n   = 1'b0;
    trip_n  = 1'b0;
    case (state)
      PLLRST: begin
        pll_n   = 1'b1;
        stage_n = '1;
        if (cnt == CNT_W'(PLL_RST_CYCLES - 1)) begin
          state_n = WAIT_LOCK;
          cnt_n   = '0;
          pll_n   = 1'b0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      WAIT_LOCK: begin
        if (lock_s) begin
          state_n = STABLE;
          cnt_n   = CNT_W'(1);
        end
      end
      STABLE: begin
        if (!lock_s) begin
          state_n = WAIT_LOCK;
          cnt_n   = '0;
        end else if (cnt == CNT_W'(LOCK_CYCLES)) begin
          // Release shifts a zero in from bit 0; all-zero means every domain is out.
          stage_n = stage_rst << 1;
          state_n = (stage_n == '0) ? RUN : RELEASE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      RELEASE: begin
        if (!lock_s) begin
          stage_n = '1;
          state_n = WAIT_LOCK;
          cnt_n   = '0;
        end else if (cnt == CNT_W'(STAGE_GAP - 1)) begin
          stage_n = stage_rst << 1;
          state_n = (stage_n == '0) ? RUN : RELEASE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      RUN: begin
        if (!lock_s) begin
          stage_n = '1;
          state_n = WAIT_LOCK;
          cnt_n   = '0;
        end
      end
      SWHOLD: begin
        stage_n = '1;
        if (cnt == CNT_W'(SWRST_HOLD - 1)) begin
          state_n = WAIT_LOCK;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        state_n = PLLRST;
        cnt_n   = '0;
        stage_n = '1;
        pll_n   = 1'b1;
      end
    endcase

    // Overrides applied lowest priority first so the software request wins.
    if (wdt_hit) begin
      state_n = PLLRST;
      cnt_n   = '0;
      stage_n = '1;
      pll_n   = 1'b1;
      trip_n  = 1'b1;
    end
    if (sw_rst_req_i && (state != PLLRST)) begin
      state_n = SWHOLD;
      cnt_n   = '0;
      stage_n = '1;
      pll_n   = 1'b0;
      trip_n  = 1'b0;
    end

    ready_n = (state_n == RUN);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state     <= PLLRST;
      cnt       <= '0;
      stage_rst <= '1;
      pll_rst   <= 1'b1;
      ready     <= 1'b0;
      trip      <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      stage_rst <= stage_n;
      pll_rst   <= pll_n;
      ready     <= ready_n;
      trip      <= trip_n;
    end
  end

  assign pll_rst_o   = pll_rst;
  assign stage_rst_o = stage_rst;
  assign ready_o     = ready;
  assign wdt_trip_o  = trip;

endmodule

// File: tb/tb_skywave_rst_seq.sv
// tb_skywave_rst_seq: directed self-checking bench for skywave_rst_seq.
// Parameters: NSTAGES=3, PLL_RST_CYCLES=4, LOCK_CYCLES=8, STAGE_GAP=4,
// SWRST_HOLD=4, WDT_CYCLES=64. Watchdog expectations follow
// SKYWAVE_RSTSEQ_WDT_EN.
module tb_skywave_rst_seq;

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic       pll_locked_i;
  logic       sw_rst_req_i;
  logic       pll_rst_o;
  logic [2:0] stage_rst_o;
  logic       ready_o;
  logic       wdt_trip_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  skywave_rst_seq #(
    .NSTAGES        (3),
    .PLL_RST_CYCLES (4),
    .LOCK_CYCLES    (8),
    .STAGE_GAP      (4),
    .SWRST_HOLD     (4),
    .WDT_CYCLES     (64)
  ) dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .pll_locked_i (pll_locked_i),
    .sw_rst_req_i (sw_rst_req_i),
    .pll_rst_o    (pll_rst_o),
    .stage_rst_o  (stage_rst_o),
    .ready_o      (ready_o),
    .wdt_trip_o   (wdt_trip_o)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Leaves the bench 1 time unit after an edge with reset_i just dropped;
  // the next rising edge is edge 1.
  task automatic apply_reset(input logic lock);
    reset_i      = 1'b1;
    sw_rst_req_i = 1'b0;
    pll_locked_i = lock;
    repeat (2) tick();
    reset_i = 1'b0;
  endtask

  // Stage pattern at edge k when lock_s was first seen high at edge e:
  // stage i releases at e + 8 + 4*i.
  function automatic logic [2:0] exp_stage(input int k, input int e);
    if (k < e + 8)       return 3'b111;
    else if (k < e + 12) return 3'b110;
    else if (k < e + 16) return 3'b100;
    else                 return 3'b000;
  endfunction

  task automatic test_reset();
    logic [5:0] got;
    reset_i      = 1'b0;
    pll_locked_i = 1'b0;
    sw_rst_req_i = 1'b0;
    #1 reset_i = 1'b1;
    #1;
    got = {pll_rst_o, stage_rst_o, ready_o, wdt_trip_o};
    checks++;
    if (got !== 6'b1_111_0_0) begin
      errors++;
      $display("FAIL reset_async got=%b exp=%b", got, 6'b1_111_0_0);
    end
    repeat (3) tick();
    got = {pll_rst_o, stage_rst_o, ready_o, wdt_trip_o};
    checks++;
    if (got !== 6'b1_111_0_0) begin
      errors++;
      $display("FAIL reset_held got=%b exp=%b", got, 6'b1_111_0_0);
    end
  endtask

  // Lock high from the start; lock_s is first seen in WAIT_LOCK at edge 5.
  // A software request during PLLRST (edge 2) must be ignored.
  task automatic test_power_on();
    logic [5:0] got, exp;
    apply_reset(1'b1);
    for (int k = 1; k <= 24; k++) begin
      sw_rst_req_i = (k == 2);
      tick();
      sw_rst_req_i = 1'b0;
      got = {pll_rst_o, stage_rst_o, ready_o, wdt_trip_o};
      exp = {(k < 4), exp_stage(k, 5), (k >= 21), 1'b0};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL power_on edge=%0d got=%b exp=%b", k, got, exp);
      end
    end
  endtask

  // Lock low for the sample at edge 8 only: lock_s is low at edge 10 while
  // count=5, back high at edge 11, so release restarts from e=11.
  task automatic test_lock_glitch();
    logic [5:0] got, exp;
    apply_reset(1'b1);
    for (int k = 1; k <= 30; k++) begin
      pll_locked_i = (k != 8);
      tick();
      got = {pll_rst_o, stage_rst_o, ready_o, wdt_trip_o};
      exp = {(k < 4), exp_stage(k, 11), (k >= 27), 1'b0};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL lock_glitch edge=%0d got=%b exp=%b", k, got, exp);
      end
    end
  endtask

  // Starts in RUN. Lock low for one sample at relative edge 1: lock_s falls
  // at 2, stages re-assert at 3, lock_s high again at 4 -> release 12/16/20.
  task automatic test_run_lock_drop();
    logic [5:0] got, exp;
    for (int k = 1; k <= 22; k++) begin
      pll_locked_i = (k != 1);
      tick();
      got = {pll_rst_o, stage_rst_o, ready_o, wdt_trip_o};
      exp = {1'b0, (k < 3) ? 3'b000 : exp_stage(k, 4), (k < 3) || (k >= 20), 1'b0};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL run_lock_drop edge=%0d got=%b exp=%b", k, got, exp);
      end
    end
  endtask

  // Starts in RUN. Software request lands on the same edge (3) as the lock
  // loss: SWHOLD for edges 3..6, WAIT_LOCK at 7, lock seen at 8 -> 16/20/24.
  task automatic test_swrst_vs_lock();
    logic [5:0] got, exp;
    for (int k = 1; k <= 26; k++) begin
      pll_locked_i = (k != 1);
      sw_rst_req_i = (k == 3);
      tick();
      sw_rst_req_i = 1'b0;
      got = {pll_rst_o, stage_rst_o, ready_o, wdt_trip_o};
      exp = {1'b0, (k < 3) ? 3'b000 : exp_stage(k, 8), (k < 3) || (k >= 24), 1'b0};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL swrst_vs_lock edge=%0d got=%b exp=%b", k, got, exp);
      end
    end
  endtask

  // Lock never asserted; WAIT_LOCK entered at edge 4.
  task automatic test_watchdog();
    logic [5:0] got, exp;
    logic       exp_pll, exp_trip;
    apply_reset(1'b0);
    for (int k = 1; k <= 80; k++) begin
      tick();
`ifdef SKYWAVE_RSTSEQ_WDT_EN
      exp_pll  = (k < 4) || ((k >= 68) && (k < 72));
      exp_trip = (k == 68);
`else
      exp_pll  = (k < 4);
      exp_trip = 1'b0;
`endif
      got = {pll_rst_o, stage_rst_o, ready_o, wdt_trip_o};
      exp = {exp_pll, 3'b111, 1'b0, exp_trip};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL watchdog edge=%0d got=%b exp=%b", k, got, exp);
      end
    end
  endtask

  task automatic test_reset_mid_release();
    logic [5:0] got;
    apply_reset(1'b1);
    repeat (13) tick();
    got = {pll_rst_o, stage_rst_o, ready_o, wdt_trip_o};
    checks++;
    if (got !== 6'b0_110_0_0) begin
      errors++;
      $display("FAIL mid_release_pre got=%b exp=%b", got, 6'b0_110_0_0);
    end
    #2 reset_i = 1'b1;
    #1;
    got = {pll_rst_o, stage_rst_o, ready_o, wdt_trip_o};
    checks++;
    if (got !== 6'b1_111_0_0) begin
      errors++;
      $display("FAIL mid_release_async got=%b exp=%b", got, 6'b1_111_0_0);
    end
    tick();
    reset_i = 1'b0;
    tick();
    got = {pll_rst_o, stage_rst_o, ready_o, wdt_trip_o};
    checks++;
    if (got !== 6'b1_111_0_0) begin
      errors++;
      $display("FAIL mid_release_restart got=%b exp=%b", got, 6'b1_111_0_0);
    end
  endtask

  initial begin
    test_reset();
    test_power_on();
    test_lock_glitch();
    test_run_lock_drop();
    test_swrst_vs_lock();
    test_watchdog();
    test_reset_mid_release();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/skywave_rst_seq.md
# skywave_rst_seq

Clock/reset sequencer for the Skywave-A SoC. Holds the PLL in reset after power-on, qualifies PLL lock for a stable window, and releases a set of downstream reset domains one by one in a fixed order. Any loss of lock or software reset request re-asserts all domain resets. Sits between the SoC PLL and every block reset in the top level.

## Interface
- NSTAGES, 4: number of sequenced reset domains (1..8)
- PLL_RST_CYCLES, 4: cycles pll_rst_o is held after reset_i deasserts
- LOCK_CYCLES, 256: consecutive synced-lock cycles required before first release (≥2)
- STAGE_GAP, 16: cycles between consecutive stage releases (≥1)
- SWRST_HOLD, 8: cycles all stages stay asserted after a software reset request (≥1)
- WDT_CYCLES, 65536: lock watchdog timeout (only with SKYWAVE_RSTSEQ_WDT_EN)
- clk_i  in  1  system clock; only clock
- reset_i  in  1  asynchronous, active-high reset
- pll_locked_i  in  1  PLL lock, asynchronous to clk_i
- sw_rst_req_i  in  1  single-cycle synchronous software reset request
- pll_rst_o  out  1  PLL reset, active-high
- stage_rst_o  out  NSTAGES  per-domain reset, active-high; bit 0 released first
- ready_o  out  1  high only when every stage is released
- wdt_trip_o  out  1  one-cycle pulse on watchdog timeout

## Operation
- pll_locked_i passes through a 2-flop synchronizer; the FSM sees only lock_s.
- States: PLLRST, WAIT_LOCK, STABLE, RELEASE, RUN, SWHOLD.
- PLLRST: pll_rst_o=1, all stages asserted. After PLL_RST_CYCLES cycles: pll_rst_o=0, go to WAIT_LOCK.
- WAIT_LOCK: lock_s=1 → STABLE with count=1.
- STABLE: lock_s=1 increments count; count reaching LOCK_CYCLES → RELEASE and clears stage_rst_o[0] on that edge. lock_s=0 → WAIT_LOCK, count cleared.
- RELEASE: every STAGE_GAP cycles clear the next stage bit in ascending order. The edge that clears bit NSTAGES-1 enters RUN and sets ready_o=1. NSTAGES=1: goes from STABLE directly to RUN.
- RUN: holds. lock_s=0 in RELEASE or RUN → all stage bits set, ready_o=0, go to WAIT_LOCK on that edge. pll_rst_o stays 0.
- sw_rst_req_i=1 in WAIT_LOCK/STABLE/RELEASE/RUN → all stages asserted, ready_o=0, enter SWHOLD. In SWHOLD it restarts the hold count. In PLLRST it is ignored.
- SWHOLD: after SWRST_HOLD cycles → WAIT_LOCK. A full lock qualification follows.
- Priority on the same edge: sw_rst_req_i > watchdog trip > lock loss > normal progress.
- Stage bits only clear in order and only set all at once. No partial re-assert.
- Counters are sized $clog2(max+1) of their parameter. No wrap is reachable: each counter clears on every state entry.

## Timing
- Reset values: pll_rst_o=1, stage_rst_o=all ones, ready_o=0, wdt_trip_o=0, state=PLLRST. Assertion is immediate (async); all deassertion is synchronous to clk_i.
- Edge 1 is the first clk_i edge after reset_i falls. pll_rst_o falls at edge PLL_RST_CYCLES.
- If lock_s is first seen high in WAIT_LOCK at edge E, stage i releases at edge E+LOCK_CYCLES+i·STAGE_GAP. ready_o rises with the last stage.
- pll_locked_i to lock_s latency: 2 cycles.
- Lock loss (lock_s=0) to all stages asserted: 1 edge.
- A reset_i assert mid-sequence returns all outputs to their reset values at once.

## Configuration
- SKYWAVE_RSTSEQ_WDT_EN defined: a counter runs while in WAIT_LOCK or STABLE and clears on entering either from any other state.
  - Reaching WDT_CYCLES → PLLRST (pll_rst_o=1 for PLL_RST_CYCLES cycles) and wdt_trip_o pulses high for 1 cycle on that edge.
- Undefined: no watchdog logic; wdt_trip_o tied 0; WAIT_LOCK waits indefinitely.

## Structure
- skywave_pkg: rstseq_state_e enum (the 6 states above).
- Sub-module skywave_sync2: generic 2-flop synchronizer with async active-high reset to 0, used for pll_locked_i.

## Test plan
Bench params: NSTAGES=3, PLL_RST_CYCLES=4, LOCK_CYCLES=8, STAGE_GAP=4, SWRST_HOLD=4, WDT_CYCLES=64.
- Power-on, lock high from start → pll_rst_o falls at edge 4; stage_rst_o goes 111→110→100→000 at E+8, E+12, E+16; ready_o rises at E+16.
- Lock glitch low for 1 cycle at count 5 in STABLE → returns to WAIT_LOCK; release timing restarts from the next high.
- Lock drop in RUN → stage_rst_o=111, ready_o=0 one edge after lock_s falls; re-release follows the full 8+2·4 cycles.
- sw_rst_req_i pulse in RUN together with lock drop → SWHOLD wins; all stages asserted for 4 cycles, then WAIT_LOCK.
- With macro, lock never asserted → wdt_trip_o pulse at 64 cycles after WAIT_LOCK entry; pll_rst_o high 4 cycles. Without macro → no trip.
- reset_i asserted during RELEASE (stage_rst_o=110) → all outputs at reset values immediately, without waiting for a clk_i edge.
